// File: rtl/disp_pkg.sv
// Shared constants and FSM encoding for the display BCD converter.
package disp_pkg;

  localparam int BCD_W      = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DIGITS = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added
// so that the following left shift carries into the next decade.
module bcd_add3
  import disp_pkg::*;
(
  input  logic [BCD_W-1:0] d_i,
  output logic [BCD_W-1:0] d_o
);

  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/disp_bcd_conv.sv
// Sequential double-dabble binary-to-BCD converter for display paths.
// Define DISP_SIGNED_EN to convert two's-complement input with a sign flag.
module disp_bcd_conv
  import disp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BCD_W*DIGITS-1:0]   bcd_out,
  output logic                      neg
);

  localparam int BW = BCD_W * DIGITS;
  localparam int CW = $clog2(DATA_W + 1);

  if (pow10(DIGITS) <= (64'd1 << DATA_W) - 64'd1) begin : g_range_chk
    $error("disp_bcd_conv: DIGITS cannot hold 2^DATA_W-1");
  end

  state_e            state_q, state_d;
  logic [DATA_W-1:0] opnd_q, opnd_d, mag;
  logic [BW-1:0]     scr_q, scr_d, adj;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d_i (scr_q[g*BCD_W +: BCD_W]),
      .d_o (adj[g*BCD_W +: BCD_W])
    );
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign bcd_out   = bcd_q;
  assign last      = (cnt_q == CW'(1));

`ifdef DISP_SIGNED_EN
  logic sgn_q, sgn_d, neg_q, neg_d;
  // Most negative value wraps to itself, which reads as its magnitude.
  assign mag = in_data[DATA_W-1] ? (~in_data + 1'b1) : in_data;
  assign neg = neg_q;
`else
  assign mag = in_data;
  assign neg = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
`ifdef DISP_SIGNED_EN
    sgn_d   = sgn_q;
    neg_d   = neg_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SHIFT;
          opnd_d  = mag;
          scr_d   = '0;
          cnt_d   = CW'(DATA_W);
`ifdef DISP_SIGNED_EN
          sgn_d   = in_data[DATA_W-1];
`endif
        end
      end
      SHIFT: begin
        scr_d  = {adj[BW-2:0], opnd_q[DATA_W-1]};
        opnd_d = {opnd_q[DATA_W-2:0], 1'b0};
        cnt_d  = cnt_q - 1'b1;
        if (last) begin
          state_d = DONE;
          bcd_d   = scr_d;
`ifdef DISP_SIGNED_EN
          neg_d   = sgn_q;
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opnd_q  <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

`ifdef DISP_SIGNED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_q <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      sgn_q <= sgn_d;
      neg_q <= neg_d;
    end
  end
`endif

endmodule

// File: tb/tb_disp_bcd_conv.sv
// Randomised and directed bench for disp_bcd_conv against a decimal model.
// Compile with DISP_SIGNED_EN to exercise the signed build.
module tb_disp_bcd_conv;

  localparam int DW = 8;

`ifdef DISP_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, neg;
  logic [11:0] bcd_out;

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  disp_bcd_conv #(.DATA_W(8), .DIGITS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd_out   (bcd_out),
    .neg       (neg)
  );

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, got, exp, cyc);
    end
  endtask

  // Decimal value the display must show for an input byte
  function automatic logic [11:0] m_bcd_of(input logic [7:0] v);
    int m;
    m = int'(v);
    if (SGN && v[7]) m = 256 - m;
    return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic logic m_neg_of(input logic [7:0] v);
    return SGN && v[7];
  endfunction

  // Transaction-level model: one pending job, result after DW cycles
  logic        m_pend;
  int          m_age;
  logic [11:0] m_res, m_bcd;
  logic        m_rneg, m_neg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 1'b0;
      m_age  <= 0;
      m_res  <= '0;
      m_rneg <= 1'b0;
      m_bcd  <= '0;
      m_neg  <= 1'b0;
    end else if (m_pend) begin
      if (m_age == DW) begin
        if (out_ready) m_pend <= 1'b0;
      end else begin
        m_age <= m_age + 1;
        if (m_age + 1 == DW) begin
          m_bcd <= m_res;
          m_neg <= m_rneg;
        end
      end
    end else if (in_valid) begin
      m_pend <= 1'b1;
      m_age  <= 0;
      m_res  <= m_bcd_of(in_data);
      m_rneg <= m_neg_of(in_data);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cmp_in_ready", in_ready, !m_pend);
      check("cmp_out_valid", out_valid, m_pend && (m_age == DW));
      check("cmp_bcd", bcd_out, m_bcd);
      check("cmp_neg", neg, m_neg);
    end
  end

  task automatic wait_ready();
    int t;
    t = 0;
    while (!in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic wait_out(input int acc, input logic [11:0] exp,
                          input logic en);
    int t;
    t = 0;
    while (!out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("latency", cyc - acc, DW);
    check("bcd", bcd_out, exp);
    check("neg", neg, en);
  endtask

  task automatic conv(input logic [7:0] v, input logic [11:0] exp,
                      input logic en);
    int acc;
    @(negedge clk);
    in_data = v;
    in_valid = 1'b1;
    out_ready = 1'b1;
    wait_ready();
    @(negedge clk);
    acc = cyc;
    in_valid = 1'b0;
    wait_out(acc, exp, en);
  endtask

  initial begin
    int acc;
    int n;
    int tv[2];
    logic [11:0] bv[2];

    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_bcd", bcd_out, 0);
    check("rst_neg", neg, 0);
    @(negedge clk);
    rst_n = 1'b1;

    conv(8'hFF, SGN ? 12'h001 : 12'h255, SGN);
    conv(8'h00, 12'h000, 1'b0);
    conv(8'h64, 12'h100, 1'b0);
    conv(8'h09, 12'h009, 1'b0);
    conv(8'h80, 12'h128, SGN);
    conv(8'h7F, 12'h127, 1'b0);

    // Stall in DONE with in_valid pulses that must be ignored
    @(negedge clk);
    in_data = 8'h2A;
    in_valid = 1'b1;
    out_ready = 1'b0;
    wait_ready();
    @(negedge clk);
    acc = cyc;
    in_valid = 1'b0;
    wait_out(acc, 12'h042, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("stall_ov", out_valid, 1);
      check("stall_ir", in_ready, 0);
      check("stall_bcd", bcd_out, 12'h042);
      in_valid = (i % 2 == 1);
      in_data = 8'h99;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_ir", in_ready, 1);
    check("release_ov", out_valid, 0);

    // Reset during the fourth shift cycle
    in_data = 8'h37;
    in_valid = 1'b1;
    wait_ready();
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_ir", in_ready, 1);
    check("arst_ov", out_valid, 0);
    check("arst_bcd", bcd_out, 0);
    check("arst_neg", neg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    in_data = 8'hC8;
    in_valid = 1'b1;
    @(negedge clk);
    acc = cyc;
    in_valid = 1'b0;
    check("post_rst_accept", in_ready, 0);
    wait_out(acc, SGN ? 12'h056 : 12'h200, SGN);

    // Back-to-back 9 then 200
    @(negedge clk);
    in_data = 8'd9;
    in_valid = 1'b1;
    out_ready = 1'b1;
    wait_ready();
    @(negedge clk);
    in_data = 8'd200;
    n = 0;
    for (int i = 0; i < 40 && n < 2; i++) begin
      if (out_valid) begin
        tv[n] = cyc;
        bv[n] = bcd_out;
        n++;
      end
      if (n < 2) @(negedge clk);
    end
    in_valid = 1'b0;
    check("b2b_count", n, 2);
    if (n == 2) begin
      check("b2b_first", bv[0], 12'h009);
      check("b2b_second", bv[1], SGN ? 12'h056 : 12'h200);
      check("b2b_spacing", tv[1] - tv[0], 10);
    end

    // Random traffic checked by the compare process
    repeat (600) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 2) != 0);
      in_data = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
